// File: rtl/cdc_handshake_tx_if.sv
// Interface bundling the local valid/ready side and the far-domain req/ack
// side of the toggle-handshake transmitter.
// slave  : the transmitter itself.
// master : the environment, which drives the local word and the returned ack.
interface cdc_handshake_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_req;
    logic [WIDTH-1:0] o_data;
    logic             i_ack;
    logic             o_done;
    logic             o_proto_err;
    logic             o_timeout;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ack,
        output o_ready,
        output o_req,
        output o_data,
        output o_done,
        output o_proto_err,
        output o_timeout
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ack,
        input  o_ready,
        input  o_req,
        input  o_data,
        input  o_done,
        input  o_proto_err,
        input  o_timeout
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a 2-phase (toggle) req/ack clock-domain crossing.
// A word accepted on the local valid/ready side is held on o_data while o_req
// toggles; the far-domain ack is resynchronised through an ASYNC_REG chain and
// the block frees itself once the synchronised ack equals o_req.
// Optional feature: define CDC_TX_TIMEOUT_EN to enable the WAIT_ACK watchdog
// that pulses o_timeout every TIMEOUT_CYCLES+1 cycles without aborting.
module cdc_handshake_tx #(
    parameter int unsigned      WIDTH          = 8,
    parameter int unsigned      STEP           = 2,
    parameter logic [WIDTH-1:0] INIT           = '0,
    parameter int unsigned      TIMEOUT_CYCLES = 1023
) (
    input  logic                i_clk,
    input  logic                i_rst,
    cdc_handshake_tx_if.slave   bus
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    (* ASYNC_REG = "TRUE" *) logic [STEP-1:0] ack_s_q;
    logic ack_y;

    assign ack_y = ack_s_q[STEP-1];

    // Resynchronise the far-domain ack toggle into i_clk.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_s_q <= '0;
        end else begin
            ack_s_q <= {ack_s_q[STEP-2:0], bus.i_ack};
        end
    end

    // Handshake state and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= INIT;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; accept is gated on the registered ready so a word
    // presented on the first cycle after reset is not captured.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (ack_y != req_q) begin
                    err_d = 1'b1;
                end
                if (bus.i_valid && ready_q) begin
                    data_d  = bus.i_data;
                    req_d   = ~req_q;
                    ready_d = 1'b0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                ready_d = 1'b0;
                if (ack_y == req_q) begin
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CDC_TX_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    // Watchdog counter: zero in IDLE, so it always starts at 0 on WAIT_ACK entry.
    always_comb begin
        cnt_d = '0;
        to_d  = 1'b0;
        if (state_q == WAIT_ACK) begin
            if (cnt_q == CNT_LAST) begin
                to_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign bus.o_timeout = to_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign bus.o_timeout      = 1'b0;
`endif

    assign bus.o_ready     = ready_q;
    assign bus.o_req       = req_q;
    assign bus.o_data      = data_q;
    assign bus.o_done      = done_q;
    assign bus.o_proto_err = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (WIDTH=8, STEP=2, INIT=8'h5A).
// A cycle table covers reset release, transfer, hold stability, ack latency,
// and the spurious-ack error; hand sequences cover async reset mid-transfer,
// exact ack latency and (with CDC_TX_TIMEOUT_EN) the watchdog pulses.
module tb_cdc_handshake_tx;

    localparam logic [7:0] INIT_V = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cdc_handshake_tx_if #(.WIDTH(8)) bus ();

    cdc_handshake_tx #(
        .WIDTH(8),
        .STEP(2),
        .INIT(INIT_V)
`ifdef CDC_TX_TIMEOUT_EN
        , .TIMEOUT_CYCLES(15)
`endif
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       ack;
        logic       ready;
        logic       req;
        logic [7:0] odata;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        int t1;
        int t2;
        int tcount;

        //               valid data  ack | ready req odata  done err
        vecs[0]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1};

        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_ack   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.o_ready), 32'd0);
        chk("rst_req", 32'(bus.o_req), 32'd0);
        chk("rst_data", 32'(bus.o_data), 32'(INIT_V));
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_err", 32'(bus.o_proto_err), 32'd0);
        chk("rst_timeout", 32'(bus.o_timeout), 32'd0);
        rst = 1'b0;

        // Cycle table
        for (int i = 0; i < 20; i++) begin
            bus.i_valid = vecs[i].valid;
            bus.i_data  = vecs[i].data;
            bus.i_ack   = vecs[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.o_ready), 32'(vecs[i].ready));
            chk($sformatf("v%0d_req", i), 32'(bus.o_req), 32'(vecs[i].req));
            chk($sformatf("v%0d_data", i), 32'(bus.o_data), 32'(vecs[i].odata));
            chk($sformatf("v%0d_done", i), 32'(bus.o_done), 32'(vecs[i].done));
            chk($sformatf("v%0d_err", i), 32'(bus.o_proto_err), 32'(vecs[i].err));
            chk($sformatf("v%0d_timeout", i), 32'(bus.o_timeout), 32'd0);
        end
        bus.i_valid = 1'b0;

        // Asynchronous reset while WAIT_ACK (word C3 pending)
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(bus.o_req), 32'd0);
        chk("arst_data", 32'(bus.o_data), 32'(INIT_V));
        chk("arst_ready", 32'(bus.o_ready), 32'd0);
        chk("arst_err", 32'(bus.o_proto_err), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_ready", 32'(bus.o_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rec_ready", 32'(bus.o_ready), 32'd1);

        // Recovery transfer with exact ack latency
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h96;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        chk("rec_req", 32'(bus.o_req), 32'd1);
        chk("rec_data", 32'(bus.o_data), 32'h96);
        chk("rec_busy", 32'(bus.o_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rec_wait_ready", 32'(bus.o_ready), 32'd0);
        bus.i_ack = 1'b1;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.o_done === 1'b1) break;
        end
        chk("lat_edges", 32'(n), 32'd3);
        chk("lat_ready", 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(bus.o_done), 32'd0);
        chk("rec_err", 32'(bus.o_proto_err), 32'd0);

`ifdef CDC_TX_TIMEOUT_EN
        // Withheld ack: watchdog pulses after WAIT_ACK edges 16 and 32
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h77;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        chk("to_req", 32'(bus.o_req), 32'd0);
        t1 = 0;
        t2 = 0;
        tcount = 0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_timeout === 1'b1) begin
                tcount++;
                if (tcount == 1) t1 = k;
                if (tcount == 2) t2 = k;
            end
        end
        chk("to_first", 32'(t1), 32'd16);
        chk("to_second", 32'(t2), 32'd32);
        chk("to_count", 32'(tcount), 32'd2);
        chk("to_still_wait", 32'(bus.o_ready), 32'd0);
        bus.i_ack = 1'b0;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.o_done === 1'b1) break;
        end
        chk("to_late_ack", 32'(n), 32'd3);
`else
        n = 0;
        t1 = 0;
        t2 = 0;
        tcount = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
